mem_ctrl: RTL and testbench

Responder end of the byte-serial memory interface used by the fetch stage and the memory stage. Arbitrates between an instruction-fetch port and a data port, drives the single byte-wide RAM port, and returns read bytes and assembled words with strobes. Sits between the pipeline stages and the external RAM; it is the only block that drives RAM address and write strobe.

---
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Byte-serial memory bus between the pipeline stages, the external RAM and mem_ctrl.
// slave is the controller's view; master is the requesters'/RAM's view.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_byte_valid;
  logic [7:0]        if_byte;
  logic [31:0]       if_inst;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;
  logic              io_full;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din, io_full,
    output if_byte_valid, if_byte, if_inst, if_done, mem_rdata, mem_done, ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din, io_full,
    input  if_byte_valid, if_byte, if_inst, if_done, mem_rdata, mem_done, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and data requests onto a single byte-wide RAM port (data port has priority).
// Define MEM_CTRL_IO_STALL_EN to hold IO-region writes while io_full is asserted.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIfRd, StMemRd, StMemWr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic              if_byte_valid_q, if_byte_valid_d;
  logic [7:0]        if_byte_q, if_byte_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  logic [2:0]        mem_n;
  logic [2:0]        cnt_inc;
  logic [1:0]        lane_rd;
  logic [1:0]        lane_wr;
  logic              stall_new;
  logic              stall_cur;

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall_new = bus.io_full && (bus.mem_addr[ADDR_W-1 -: 2] == IO_HI);
  assign stall_cur = bus.io_full && (base_q[ADDR_W-1 -: 2] == IO_HI);
`else
  logic unused_io;
  assign unused_io = bus.io_full ^ (^IO_HI);
  assign stall_new = 1'b0;
  assign stall_cur = 1'b0;
`endif

  always_comb begin
    case (bus.mem_len)
      2'b00:   mem_n = 3'd1;
      2'b01:   mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  // Reads: cnt_q counts cycles since the first busy cycle; ram_din for lane c-1 arrives at c.
  // Writes: cnt_q is the lane currently on the RAM port; a low ram_wr_q means it is stalled.
  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    n_d             = n_q;
    cnt_d           = cnt_q;
    wdata_d         = wdata_q;
    rbuf_d          = rbuf_q;
    if_byte_valid_d = 1'b0;
    if_byte_d       = if_byte_q;
    if_inst_d       = if_inst_q;
    if_done_d       = 1'b0;
    mem_rdata_d     = mem_rdata_q;
    mem_done_d      = 1'b0;
    ram_a_d         = ram_a_q;
    ram_dout_d      = ram_dout_q;
    ram_wr_d        = 1'b0;
    cnt_inc         = cnt_q + 3'd1;
    lane_rd         = 2'(cnt_q - 3'd1);
    lane_wr         = cnt_inc[1:0];

    unique case (state_q)
      StIdle: begin
        // A done pulse blocks acceptance so a still-held request is not retriggered.
        if (!if_done_q && !mem_done_q && (bus.mem_req || bus.if_req)) begin
          cnt_d  = 3'd0;
          rbuf_d = '0;
          if (bus.mem_req) begin
            base_d  = bus.mem_addr;
            n_d     = mem_n;
            wdata_d = bus.mem_wdata;
            ram_a_d = bus.mem_addr;
            if (bus.mem_we) begin
              state_d    = StMemWr;
              ram_dout_d = bus.mem_wdata[7:0];
              ram_wr_d   = !stall_new;
            end else begin
              state_d = StMemRd;
            end
          end else begin
            base_d  = bus.if_addr;
            n_d     = 3'd4;
            ram_a_d = bus.if_addr;
            state_d = StIfRd;
          end
        end
      end

      StIfRd, StMemRd: begin
        cnt_d = cnt_inc;
        if (cnt_inc < n_q) begin
          ram_a_d = base_q + ADDR_W'(cnt_inc);
        end
        if (cnt_q != 3'd0) begin
          rbuf_d[8*lane_rd +: 8] = bus.ram_din;
          if (state_q == StIfRd) begin
            if_byte_valid_d = 1'b1;
            if_byte_d       = bus.ram_din;
          end
        end
        if (cnt_q == n_q) begin
          state_d = StIdle;
          if (state_q == StIfRd) begin
            if_inst_d = rbuf_d;
            if_done_d = 1'b1;
          end else begin
            mem_rdata_d = rbuf_d;
            mem_done_d  = 1'b1;
          end
        end
      end

      StMemWr: begin
        if (!ram_wr_q) begin
          ram_wr_d = !stall_cur;
        end else if (cnt_inc < n_q) begin
          cnt_d      = cnt_inc;
          ram_a_d    = base_q + ADDR_W'(cnt_inc);
          ram_dout_d = wdata_q[8*lane_wr +: 8];
          ram_wr_d   = !stall_cur;
        end else begin
          mem_done_d = 1'b1;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      base_q          <= '0;
      n_q             <= '0;
      cnt_q           <= '0;
      wdata_q         <= '0;
      rbuf_q          <= '0;
      if_byte_valid_q <= 1'b0;
      if_byte_q       <= '0;
      if_inst_q       <= '0;
      if_done_q       <= 1'b0;
      mem_rdata_q     <= '0;
      mem_done_q      <= 1'b0;
      ram_a_q         <= '0;
      ram_dout_q      <= '0;
      ram_wr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      n_q             <= n_d;
      cnt_q           <= cnt_d;
      wdata_q         <= wdata_d;
      rbuf_q          <= rbuf_d;
      if_byte_valid_q <= if_byte_valid_d;
      if_byte_q       <= if_byte_d;
      if_inst_q       <= if_inst_d;
      if_done_q       <= if_done_d;
      mem_rdata_q     <= mem_rdata_d;
      mem_done_q      <= mem_done_d;
      ram_a_q         <= ram_a_d;
      ram_dout_q      <= ram_dout_d;
      ram_wr_q        <= ram_wr_d;
    end
  end

  assign bus.if_byte_valid = if_byte_valid_q;
  assign bus.if_byte       = if_byte_q;
  assign bus.if_inst       = if_inst_q;
  assign bus.if_done       = if_done_q;
  assign bus.mem_rdata     = mem_rdata_q;
  assign bus.mem_done      = mem_done_q;
  assign bus.ram_a         = ram_a_q;
  assign bus.ram_dout      = ram_dout_q;
  assign bus.ram_wr        = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of fetch/read/write transactions plus
// hand sequences for arbitration, asynchronous reset and the optional IO write stall.
module tb_mem_ctrl;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {KIf, KRd, KWr} kind_e;

  typedef struct {
    kind_e       kind;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_word;
    int          exp_done;  // cycle offset from S of the done pulse
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W), .IO_HI(2'b11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: data for ram_a appears on ram_din the following cycle.
  logic [7:0] ram_m [0:4095];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) ram_m[i] <= 8'h00;
      ram_m[12'h100] <= 8'h13;
      ram_m[12'h101] <= 8'h00;
      ram_m[12'h102] <= 8'h00;
      ram_m[12'h103] <= 8'h93;
      ram_m[12'h206] <= 8'h5A;
      ram_m[12'h207] <= 8'h11;
      ram_m[12'hFFF] <= 8'hEF;
      ram_m[12'h000] <= 8'hBE;
      ram_m[12'h001] <= 8'hAD;
      ram_m[12'h002] <= 8'hDE;
    end else if (bus.ram_wr) begin
      ram_m[bus.ram_a[11:0]] <= bus.ram_dout;
    end
    bus.ram_din <= ram_m[bus.ram_a[11:0]];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ram_a"}, bus.ram_a, 32'h0);
    chk({tag, " ram_wr"}, 32'(bus.ram_wr), 32'h0);
    chk({tag, " ram_dout"}, 32'(bus.ram_dout), 32'h0);
    chk({tag, " if_byte_valid"}, 32'(bus.if_byte_valid), 32'h0);
    chk({tag, " if_byte"}, 32'(bus.if_byte), 32'h0);
    chk({tag, " if_inst"}, bus.if_inst, 32'h0);
    chk({tag, " if_done"}, 32'(bus.if_done), 32'h0);
    chk({tag, " mem_rdata"}, bus.mem_rdata, 32'h0);
    chk({tag, " mem_done"}, 32'(bus.mem_done), 32'h0);
  endtask

  // Entered at the negedge before S with the request already raised.
  task automatic observe(input vec_t v);
    int n;
    n = (v.kind == KIf) ? 4 : (v.len == 2'b00) ? 1 : (v.len == 2'b01) ? 2 : 4;
    for (int c = 0; c <= v.exp_done; c++) begin
      @(negedge clk);
      if (c < n) chk($sformatf("ram_a c%0d", c), bus.ram_a, v.addr + 32'(c));
      if (v.kind == KWr) begin
        chk($sformatf("ram_wr c%0d", c), 32'(bus.ram_wr), 32'(c < n));
        if (c < n) chk($sformatf("ram_dout c%0d", c), 32'(bus.ram_dout),
                       (v.wdata >> (8 * c)) & 32'hff);
        chk($sformatf("mem_done c%0d", c), 32'(bus.mem_done), 32'(c == v.exp_done));
      end else begin
        chk($sformatf("ram_wr c%0d", c), 32'(bus.ram_wr), 32'h0);
        if (v.kind == KIf) begin
          chk($sformatf("if_byte_valid c%0d", c), 32'(bus.if_byte_valid),
              32'(c >= 2 && c <= 5));
          if (c >= 2 && c <= 5) chk($sformatf("if_byte c%0d", c), 32'(bus.if_byte),
                                    (v.exp_word >> (8 * (c - 2))) & 32'hff);
          chk($sformatf("if_done c%0d", c), 32'(bus.if_done), 32'(c == v.exp_done));
          if (c == v.exp_done) chk("if_inst", bus.if_inst, v.exp_word);
        end else begin
          chk($sformatf("if_byte_valid c%0d", c), 32'(bus.if_byte_valid), 32'h0);
          chk($sformatf("mem_done c%0d", c), 32'(bus.mem_done), 32'(c == v.exp_done));
          if (c == v.exp_done) chk("mem_rdata", bus.mem_rdata, v.exp_word);
        end
      end
    end
    if (v.kind == KIf) bus.if_req = 1'b0;
    else bus.mem_req = 1'b0;
  endtask

  task automatic launch(input vec_t v);
    bus.mem_we    = (v.kind == KWr);
    bus.mem_addr  = v.addr;
    bus.mem_len   = v.len;
    bus.mem_wdata = v.wdata;
    if (v.kind == KIf) begin
      bus.if_addr = v.addr;
      bus.if_req  = 1'b1;
    end else begin
      bus.mem_req = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    launch(v);
    observe(v);
    @(negedge clk);
  endtask

  vec_t vecs [9];
  vec_t va, vb;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{KIf, 32'h0000_0100, 2'b00, 32'h0,         32'h9300_0013, 5};
    vecs[1] = '{KWr, 32'h0000_0204, 2'b01, 32'hA1B2_C3D4, 32'h0,         2};
    vecs[2] = '{KRd, 32'h0000_0204, 2'b00, 32'h0,         32'h0000_00D4, 2};
    vecs[3] = '{KRd, 32'h0000_0204, 2'b01, 32'h0,         32'h0000_C3D4, 3};
    vecs[4] = '{KRd, 32'h0000_0204, 2'b10, 32'h0,         32'h115A_C3D4, 5};
    vecs[5] = '{KWr, 32'h0000_0300, 2'b10, 32'hCAFE_F00D, 32'h0,         4};
    vecs[6] = '{KRd, 32'h0000_0300, 2'b10, 32'h0,         32'hCAFE_F00D, 5};
    vecs[7] = '{KIf, 32'hFFFF_FFFF, 2'b00, 32'h0,         32'hDEAD_BEEF, 5};
    vecs[8] = '{KRd, 32'h0000_0100, 2'b11, 32'h0,         32'h9300_0013, 5};

    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_len   = 2'b00;
    bus.mem_wdata = '0;
    bus.io_full   = 1'b0;

    // Reset asserted between clock edges must clear outputs at once.
    #2 rst = 1'b0;
    #1 chk_all_zero("por");
    repeat (3) @(negedge clk);
    preload = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle ram_wr", 32'(bus.ram_wr), 32'h0);
    end

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Simultaneous requests: data port first, one turnaround cycle, then the held fetch.
    va = '{KRd, 32'h0000_0100, 2'b10, 32'h0, 32'h9300_0013, 5};
    vb = '{KIf, 32'h0000_0204, 2'b00, 32'h0, 32'h115A_C3D4, 5};
    launch(va);
    bus.if_addr = vb.addr;
    bus.if_req  = 1'b1;
    observe(va);
    @(negedge clk);
    chk("turnaround if_byte_valid", 32'(bus.if_byte_valid), 32'h0);
    chk("turnaround mem_done", 32'(bus.mem_done), 32'h0);
    observe(vb);
    chk("mem_rdata held", bus.mem_rdata, 32'h9300_0013);
    @(negedge clk);

    // Mid-cycle reset after activity: outputs clear without a clock edge.
    #2 rst = 1'b0;
    #1 chk_all_zero("mid reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post reset ram_wr", 32'(bus.ram_wr), 32'h0);
      chk("post reset mem_done", 32'(bus.mem_done), 32'h0);
    end

    // Reset while the third fetch byte is being issued.
    launch(vecs[0]);
    repeat (3) @(negedge clk);
    chk("abort ram_a before reset", bus.ram_a, 32'h0000_0102);
    #1 rst = 1'b0;
    bus.if_req = 1'b0;
    #1 chk("abort ram_a", bus.ram_a, 32'h0);
    chk("abort if_byte_valid", 32'(bus.if_byte_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort if_done", 32'(bus.if_done), 32'h0);
    end
    run_vec(vecs[0]);

    // Reset during a write drops ram_wr asynchronously.
    va = '{KWr, 32'h0000_0400, 2'b10, 32'h0102_0304, 32'h0, 4};
    launch(va);
    @(negedge clk);
    chk("wr abort ram_wr before reset", 32'(bus.ram_wr), 32'h1);
    #1 rst = 1'b0;
    bus.mem_req = 1'b0;
    #1 chk("wr abort ram_wr", 32'(bus.ram_wr), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wr abort mem_done", 32'(bus.mem_done), 32'h0);
      chk("wr abort ram_wr idle", 32'(bus.ram_wr), 32'h0);
    end

    // IO-region write with io_full high across three accepting/holding edges.
    va = '{KWr, 32'hC000_0000, 2'b00, 32'h0000_0077, 32'h0, 1};
    launch(va);
    bus.io_full = 1'b1;
`ifdef MEM_CTRL_IO_STALL_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("io stall ram_wr c%0d", c), 32'(bus.ram_wr), 32'h0);
      chk($sformatf("io stall mem_done c%0d", c), 32'(bus.mem_done), 32'h0);
    end
    bus.io_full = 1'b0;
    @(negedge clk);
    chk("io stall ram_wr c3", 32'(bus.ram_wr), 32'h1);
    chk("io stall ram_a c3", bus.ram_a, 32'hC000_0000);
    chk("io stall ram_dout c3", 32'(bus.ram_dout), 32'h77);
    chk("io stall mem_done c3", 32'(bus.mem_done), 32'h0);
    @(negedge clk);
    chk("io stall ram_wr c4", 32'(bus.ram_wr), 32'h0);
    chk("io stall mem_done c4", 32'(bus.mem_done), 32'h1);
    bus.mem_req = 1'b0;
`else
    observe(va);
    bus.io_full = 1'b0;
`endif
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
